// File: rtl/usb_fast_fifo_sequencer.sv
// usb_fast_fifo_sequencer
//
// Serves byte-wide fast-FIFO reads from the USB register front end out of
// 32-bit words popped from the capture FIFO. A host-programmed burst length
// is counted down one byte per read request. Underflow (a request with no
// valid byte) and burst completion are reported to the register block.
//
// Optional build macro: USB_FIFO_PREFETCH_EN
//   Adds a second word register that is filled in the background while
//   bytes are served, so a word boundary costs no FETCH/LOAD stall.
//
// Ports:
//   cwusb_clk       USB interface clock (sole clock)
//   reset           asynchronous active-high reset
//   I_fast_fifo_rd  one-cycle byte request pulse
//   I_burst_start   one-cycle pulse arming a burst
//   I_burst_len     burst length in bytes, sampled on I_burst_start
//   I_clear_flags   clears sticky O_underflow
//   O_fifo_rd       pop strobe to capture FIFO (data valid the next cycle)
//   I_fifo_dout     capture FIFO read data
//   I_fifo_empty    capture FIFO empty
//   O_data          byte presented to the USB read mux
//   O_busy          burst in progress
//   O_done          one-cycle pulse at burst completion
//   O_underflow     sticky underflow flag
//   O_remaining     bytes left in the current burst
module usb_fast_fifo_sequencer #(
    parameter int unsigned pLEN_WIDTH      = 16,
    parameter logic [7:0]  pUNDERFLOW_BYTE = 8'hEE
) (
    input  logic                  cwusb_clk,
    input  logic                  reset,
    input  logic                  I_fast_fifo_rd,
    input  logic                  I_burst_start,
    input  logic [pLEN_WIDTH-1:0] I_burst_len,
    input  logic                  I_clear_flags,
    output logic                  O_fifo_rd,
    input  logic [31:0]           I_fifo_dout,
    input  logic                  I_fifo_empty,
    output logic [7:0]            O_data,
    output logic                  O_busy,
    output logic                  O_done,
    output logic                  O_underflow,
    output logic [pLEN_WIDTH-1:0] O_remaining
);

    typedef enum logic [1:0] {StIdle, StFetch, StLoad, StServe} state_t;

    state_t      state;
    logic [31:0] word;
    logic [1:0]  byte_idx;

    function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[8*idx +: 8];
    endfunction

`ifdef USB_FIFO_PREFETCH_EN
    logic [31:0] pf_word;
    logic        pf_valid;
    logic        pf_pend;    // background pop issued, data not yet captured
    logic [2:0]  bytes_left;
    logic        pf_ready;   // a next word is usable this cycle
    logic [31:0] pf_next;

    always_comb begin
        bytes_left = 3'd4 - {1'b0, byte_idx};
        // Data of a pending pop is on I_fifo_dout once the strobe has dropped.
        pf_ready   = pf_valid || (pf_pend && !O_fifo_rd);
        pf_next    = pf_valid ? pf_word : I_fifo_dout;
    end
`endif

    always_ff @(posedge cwusb_clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            word        <= 32'h0;
            byte_idx    <= 2'd0;
            O_fifo_rd   <= 1'b0;
            O_data      <= 8'h00;
            O_busy      <= 1'b0;
            O_done      <= 1'b0;
            O_underflow <= 1'b0;
            O_remaining <= '0;
`ifdef USB_FIFO_PREFETCH_EN
            pf_word     <= 32'h0;
            pf_valid    <= 1'b0;
            pf_pend     <= 1'b0;
`endif
        end else begin
            O_done    <= 1'b0;
            O_fifo_rd <= 1'b0;
            if (I_clear_flags) begin
                O_underflow <= 1'b0;
            end

            case (state)
                StIdle: begin
                    if (I_burst_start) begin
                        if (I_burst_len != '0) begin
                            O_remaining <= I_burst_len;
                            O_busy      <= 1'b1;
                            state       <= StFetch;
                        end else begin
                            O_done <= 1'b1;
                        end
                    end
                end

                StFetch: begin
                    if (!I_fifo_empty) begin
                        O_fifo_rd <= 1'b1;
                        state     <= StLoad;
                    end
                end

                StLoad: begin
                    // While the strobe is high the FIFO has not popped yet.
                    if (!O_fifo_rd) begin
                        word     <= I_fifo_dout;
                        byte_idx <= 2'd0;
                        O_data   <= I_fifo_dout[7:0];
                        state    <= StServe;
`ifdef USB_FIFO_PREFETCH_EN
                        pf_pend  <= 1'b0;
`endif
                    end
                end

                StServe: begin
                    if (I_fast_fifo_rd) begin
                        O_remaining <= O_remaining - pLEN_WIDTH'(1);
                        byte_idx    <= byte_idx + 2'd1;
                        if (O_remaining == pLEN_WIDTH'(1)) begin
                            // Unread bytes of the last word are dropped.
                            O_done <= 1'b1;
                            O_busy <= 1'b0;
                            state  <= StIdle;
`ifdef USB_FIFO_PREFETCH_EN
                            pf_valid <= 1'b0;
                            pf_pend  <= 1'b0;
`endif
                        end else if (byte_idx == 2'd3) begin
`ifdef USB_FIFO_PREFETCH_EN
                            if (pf_ready) begin
                                word     <= pf_next;
                                O_data   <= pf_next[7:0];
                                byte_idx <= 2'd0;
                                pf_valid <= 1'b0;
                                pf_pend  <= 1'b0;
                            end else if (pf_pend) begin
                                // Pop already in flight: LOAD picks it up.
                                state <= StLoad;
                            end else begin
                                state <= StFetch;
                            end
`else
                            state <= StFetch;
`endif
                        end else begin
                            O_data <= sel_byte(word, byte_idx + 2'd1);
                        end
                    end
`ifdef USB_FIFO_PREFETCH_EN
                    else if (pf_pend) begin
                        if (!O_fifo_rd) begin
                            pf_word  <= I_fifo_dout;
                            pf_valid <= 1'b1;
                            pf_pend  <= 1'b0;
                        end
                    end else if (!pf_valid && !I_fifo_empty &&
                                 O_remaining > pLEN_WIDTH'(bytes_left)) begin
                        O_fifo_rd <= 1'b1;
                        pf_pend   <= 1'b1;
                    end
`endif
                end

                default: state <= StIdle;
            endcase

            // A request with no valid byte; placed last so it overrides LOAD.
            if (I_fast_fifo_rd && state != StServe) begin
                O_underflow <= 1'b1;
                O_data      <= pUNDERFLOW_BYTE;
            end
        end
    end

endmodule

// File: tb/tb_usb_fast_fifo_sequencer.sv
module tb_usb_fast_fifo_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd = 1'b0;
    logic        start = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] len = 16'd0;
    logic        fifo_rd;
    logic [31:0] dout;
    logic        empty;
    logic [7:0]  data;
    logic        busy;
    logic        done;
    logic        uf;
    logic [15:0] rem;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    usb_fast_fifo_sequencer #(
        .pLEN_WIDTH      (16),
        .pUNDERFLOW_BYTE (8'hEE)
    ) dut (
        .cwusb_clk      (clk),
        .reset          (rst),
        .I_fast_fifo_rd (rd),
        .I_burst_start  (start),
        .I_burst_len    (len),
        .I_clear_flags  (clr),
        .O_fifo_rd      (fifo_rd),
        .I_fifo_dout    (dout),
        .I_fifo_empty   (empty),
        .O_data         (data),
        .O_busy         (busy),
        .O_done         (done),
        .O_underflow    (uf),
        .O_remaining    (rem)
    );

    // Capture FIFO model: standard (non fall-through) read timing.
    logic [31:0] fq[$];
    int          fcnt = 0;
    int          rd_cnt = 0;
    logic        push_en = 1'b0;
    logic [31:0] push_data = 32'h0;

    assign empty = (fcnt == 0);

    always @(posedge clk) begin
        if (fifo_rd) begin
            rd_cnt <= rd_cnt + 1;
            if (fq.size() > 0) dout <= fq.pop_front();
        end
        if (push_en) fq.push_back(push_data);
        fcnt <= fq.size();
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        @(negedge clk);
        push_data = w;
        push_en   = 1'b1;
        @(negedge clk);
        push_en   = 1'b0;
    endtask

    task automatic start_burst(input logic [15:0] l);
        @(negedge clk);
        len   = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    // Checks n bytes of w starting at byte 0, issuing one request per gap cycles.
    task automatic serve(input logic [31:0] w, input int n, input int gap, input bit ends,
                         input string tag);
        for (int i = 0; i < n; i++) begin
            check_eq(tag, {24'h0, data}, {24'h0, w[8*i +: 8]});
            pulse();
            if (ends && i == n - 1) begin
                check_eq({tag, "_done"}, {31'h0, done}, 32'h1);
                check_eq({tag, "_busy"}, {31'h0, busy}, 32'h0);
                check_eq({tag, "_rem"}, {16'h0, rem}, 32'h0);
            end
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    int          base;
    logic [31:0] t5_word;
    int          t5_cnt;

    initial begin
        // Reset values
        @(negedge clk);
        check_eq("rst_fifo_rd", {31'h0, fifo_rd}, 32'h0);
        check_eq("rst_data", {24'h0, data}, 32'h0);
        check_eq("rst_busy", {31'h0, busy}, 32'h0);
        check_eq("rst_done", {31'h0, done}, 32'h0);
        check_eq("rst_uf", {31'h0, uf}, 32'h0);
        check_eq("rst_rem", {16'h0, rem}, 32'h0);
        rst = 1'b0;

        // 1: two full words, 8 bytes
        push(32'h44332211);
        push(32'h88776655);
        base = rd_cnt;
        start_burst(16'd8);
        check_eq("t1_busy", {31'h0, busy}, 32'h1);
        check_eq("t1_rem", {16'h0, rem}, 32'd8);
        repeat (5) @(negedge clk);
        serve(32'h44332211, 4, 6, 1'b0, "t1_w0");
        serve(32'h88776655, 4, 6, 1'b1, "t1_w1");
        check_eq("t1_pops", rd_cnt - base, 32'd2);
        check_eq("t1_uf", {31'h0, uf}, 32'h0);

        // 2: partial last word, third word untouched
        push(32'hA3A2A1A0);
        push(32'hB3B2B1B0);
        push(32'hC3C2C1C0);
        base = rd_cnt;
        start_burst(16'd5);
        repeat (5) @(negedge clk);
        serve(32'hA3A2A1A0, 4, 6, 1'b0, "t2_w0");
        serve(32'hB3B2B1B0, 1, 6, 1'b1, "t2_w1");
        check_eq("t2_pops", rd_cnt - base, 32'd2);
        check_eq("t2_fifo_left", fcnt, 32'd1);
        check_eq("t2_done_clr", {31'h0, done}, 32'h0);

        // 4: zero-length burst, then start ignored while busy
        base = rd_cnt;
        start_burst(16'd0);
        check_eq("t4_done", {31'h0, done}, 32'h1);
        check_eq("t4_busy0", {31'h0, busy}, 32'h0);
        @(negedge clk);
        check_eq("t4_done_pulse", {31'h0, done}, 32'h0);
        check_eq("t4_no_pop", rd_cnt - base, 32'd0);
        start_burst(16'd4);
        repeat (1) @(negedge clk);
        start_burst(16'd9);
        check_eq("t4_rem_kept", {16'h0, rem}, 32'd4);
        repeat (3) @(negedge clk);
        serve(32'hC3C2C1C0, 4, 6, 1'b1, "t4_w");

        // 3: underflow on empty FIFO, then recovery
        start_burst(16'd4);
        repeat (2) @(negedge clk);
        pulse();
        check_eq("t3_uf_data", {24'h0, data}, 32'hEE);
        check_eq("t3_uf", {31'h0, uf}, 32'h1);
        check_eq("t3_rem", {16'h0, rem}, 32'd4);
        push(32'hDDCCBBAA);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_eq("t3_uf_clr", {31'h0, uf}, 32'h0);
        repeat (6) @(negedge clk);
        serve(32'hDDCCBBAA, 4, 6, 1'b1, "t3_w");
        check_eq("t3_uf_end", {31'h0, uf}, 32'h0);
        // Set and clear in the same cycle: set wins
        rd  = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        rd  = 1'b0;
        clr = 1'b0;
        check_eq("t3_prio_uf", {31'h0, uf}, 32'h1);
        check_eq("t3_prio_data", {24'h0, data}, 32'hEE);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_eq("t3_uf_clr2", {31'h0, uf}, 32'h0);

        // 5: reset mid-burst
        push(32'h13121110);
        push(32'h17161514);
        push(32'h1B1A1918);
`ifdef USB_FIFO_PREFETCH_EN
        t5_word = 32'h1B1A1918;   // second word was prefetched and is lost
        t5_cnt  = 1;
`else
        t5_word = 32'h17161514;
        t5_cnt  = 2;
`endif
        start_burst(16'd8);
        repeat (5) @(negedge clk);
        serve(32'h13121110, 2, 6, 1'b0, "t5_w0");
        #2 rst = 1'b1;
        #1;
        check_eq("t5_rst_busy", {31'h0, busy}, 32'h0);
        check_eq("t5_rst_rem", {16'h0, rem}, 32'h0);
        check_eq("t5_rst_data", {24'h0, data}, 32'h0);
        check_eq("t5_rst_fifo_rd", {31'h0, fifo_rd}, 32'h0);
        check_eq("t5_rst_done", {31'h0, done}, 32'h0);
        check_eq("t5_rst_uf", {31'h0, uf}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        check_eq("t5_fifo_left", fcnt, t5_cnt);
        start_burst(16'd4);
        repeat (5) @(negedge clk);
        serve(t5_word, 4, 6, 1'b1, "t5_w1");

`ifdef USB_FIFO_PREFETCH_EN
        // 6: prefetch, requests every 2 cycles
        push(32'h23222120);
        push(32'h27262524);
        push(32'h2B2A2928);
        base = rd_cnt;
        start_burst(16'd12);
        repeat (5) @(negedge clk);
        serve(32'h23222120, 4, 2, 1'b0, "t6_w0");
        serve(32'h27262524, 4, 2, 1'b0, "t6_w1");
        serve(32'h2B2A2928, 4, 2, 1'b1, "t6_w2");
        check_eq("t6_pops", rd_cnt - base, 32'd3);
        check_eq("t6_uf", {31'h0, uf}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
